// File: rtl/lzrw1_pkg.sv
// ----------------------------------------------------------------------------
// lzrw1_pkg
//  Shared definitions for the LZRW1 decompression path (item parser and
//  decompressor_top).
//
//  Contents:
//   ITEM_W, LEN_W, OFF_W  widths of one parsed item and its copy fields
//   COPY_MIN_LEN          smallest copy length encoded by a copy item
//   parser_state_t        states of the item parser FSM
//   lzrw1_item_t          one parsed item: control bit plus 16-bit payload
// ----------------------------------------------------------------------------
package lzrw1_pkg;

    localparam int ITEM_W       = 16;
    localparam int LEN_W        = 4;
    localparam int OFF_W        = 12;
    localparam int COPY_MIN_LEN = 3;

    typedef enum logic [2:0] {
        ST_CW      = 3'd0,
        ST_ITEM_B0 = 3'd1,
        ST_ITEM_B1 = 3'd2,
        ST_EMIT    = 3'd3,
        ST_DONE    = 3'd4
    } parser_state_t;

    typedef struct packed {
        logic              is_copy;
        logic [ITEM_W-1:0] data;
    } lzrw1_item_t;

endpackage

// File: rtl/lzrw1_item_parser.sv
// ----------------------------------------------------------------------------
// lzrw1_item_parser
//  Splits a raw LZRW1 compressed byte stream into groups of one little-endian
//  control word followed by one item per control bit (LSB first), and hands
//  each item downstream as a 16-bit word plus its control bit.
//
//  Ports:
//   clock            rising-edge clock
//   reset            asynchronous active-low reset
//   clear            synchronous flush, same effect as reset for one cycle
//   in_byte/in_valid/in_last/in_ready   compressed byte stream input
//   item_data        literal {8'h00,byte} or copy {b0,b1}
//   item_is_copy     control bit belonging to item_data
//   item_valid       item_data/item_is_copy valid, held until consumed
//   downstream_busy  consumer stall; item held while high
//   stream_done      one-cycle pulse once the final item has been consumed
//   format_error     sticky; the stream ended in the middle of a copy item
// ----------------------------------------------------------------------------
module lzrw1_item_parser
    import lzrw1_pkg::*;
#(
    parameter int CW_BYTES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] item_data,
    output logic        item_is_copy,
    output logic        item_valid,
    input  logic        downstream_busy,
    output logic        stream_done,
    output logic        format_error
);

    localparam int         CW_W      = 8 * CW_BYTES;
    localparam logic [1:0] LAST_BYTE = 2'(CW_BYTES - 1);
    localparam logic [4:0] LAST_ITEM = 5'(CW_W - 1);

    parser_state_t   state_q, state_d;
    logic [CW_W-1:0] cw_shift_q, cw_shift_d;
    logic [1:0]      cw_cnt_q, cw_cnt_d;
    logic [4:0]      item_cnt_q, item_cnt_d;
    logic [7:0]      b0_q, b0_d;
    lzrw1_item_t     item_q, item_d;
    logic            last_q, last_d;
    logic            in_ready_q, in_ready_d;
    logic            item_valid_q, item_valid_d;
    logic            stream_done_q, stream_done_d;
    logic            format_error_q, format_error_d;

    logic accept;
    logic consume;

    assign accept  = in_valid & in_ready_q;
    assign consume = item_valid_q & ~downstream_busy;

    // Next-state logic. The handshake outputs are registered from the next
    // state so every output comes straight from a flop; clear overrides
    // everything, including a handshake happening in the same cycle.
    always_comb begin
        state_d        = state_q;
        cw_shift_d     = cw_shift_q;
        cw_cnt_d       = cw_cnt_q;
        item_cnt_d     = item_cnt_q;
        b0_d           = b0_q;
        item_d         = item_q;
        last_d         = last_q;
        format_error_d = format_error_q;

        if (accept && in_last) begin
            last_d = 1'b1;
        end

        case (state_q)
            ST_CW: begin
                if (accept) begin
                    for (int i = 0; i < CW_BYTES; i++) begin
                        if (cw_cnt_q == 2'(i)) begin
                            cw_shift_d[8*i +: 8] = in_byte;
                        end
                    end
                    if (in_last) begin
                        // A trailing control word with no items is legal.
                        cw_cnt_d = '0;
                        state_d  = ST_DONE;
                    end else if (cw_cnt_q == LAST_BYTE) begin
                        cw_cnt_d = '0;
                        state_d  = ST_ITEM_B0;
                    end else begin
                        cw_cnt_d = cw_cnt_q + 2'd1;
                    end
                end
            end

            ST_ITEM_B0: begin
                if (accept) begin
                    if (!cw_shift_q[0]) begin
                        item_d.is_copy = 1'b0;
                        item_d.data    = {8'h00, in_byte};
                        state_d        = ST_EMIT;
                    end else if (in_last) begin
                        // Stream stopped halfway through a copy: nothing to emit.
                        format_error_d = 1'b1;
                        state_d        = ST_DONE;
                    end else begin
                        b0_d    = in_byte;
                        state_d = ST_ITEM_B1;
                    end
                end
            end

            ST_ITEM_B1: begin
                if (accept) begin
                    item_d.is_copy = 1'b1;
                    item_d.data    = {b0_q, in_byte};
                    state_d        = ST_EMIT;
                end
            end

            ST_EMIT: begin
                if (consume) begin
                    cw_shift_d = {1'b0, cw_shift_q[CW_W-1:1]};
                    last_d     = 1'b0;
                    if (last_q) begin
                        item_cnt_d = '0;
                        state_d    = ST_DONE;
                    end else if (item_cnt_q == LAST_ITEM) begin
                        item_cnt_d = '0;
                        state_d    = ST_CW;
                    end else begin
                        item_cnt_d = item_cnt_q + 5'd1;
                        state_d    = ST_ITEM_B0;
                    end
                end
            end

            ST_DONE: begin
                // Start the next stream from a clean group boundary.
                cw_shift_d = '0;
                cw_cnt_d   = '0;
                item_cnt_d = '0;
                last_d     = 1'b0;
                state_d    = ST_CW;
            end

            default: begin
                state_d = ST_CW;
            end
        endcase

        in_ready_d    = (state_d == ST_CW) || (state_d == ST_ITEM_B0) ||
                        (state_d == ST_ITEM_B1);
        item_valid_d  = (state_d == ST_EMIT);
        stream_done_d = (state_d == ST_DONE);

        if (clear) begin
            state_d        = ST_CW;
            cw_shift_d     = '0;
            cw_cnt_d       = '0;
            item_cnt_d     = '0;
            b0_d           = '0;
            item_d         = '0;
            last_d         = 1'b0;
            format_error_d = 1'b0;
            in_ready_d     = 1'b0;
            item_valid_d   = 1'b0;
            stream_done_d  = 1'b0;
        end
    end

    // State and output registers; reset drops every output at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_CW;
            cw_shift_q     <= '0;
            cw_cnt_q       <= '0;
            item_cnt_q     <= '0;
            b0_q           <= '0;
            item_q         <= '0;
            last_q         <= 1'b0;
            in_ready_q     <= 1'b0;
            item_valid_q   <= 1'b0;
            stream_done_q  <= 1'b0;
            format_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cw_shift_q     <= cw_shift_d;
            cw_cnt_q       <= cw_cnt_d;
            item_cnt_q     <= item_cnt_d;
            b0_q           <= b0_d;
            item_q         <= item_d;
            last_q         <= last_d;
            in_ready_q     <= in_ready_d;
            item_valid_q   <= item_valid_d;
            stream_done_q  <= stream_done_d;
            format_error_q <= format_error_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign item_data    = item_q.data;
    assign item_is_copy = item_q.is_copy;
    assign item_valid   = item_valid_q;
    assign stream_done  = stream_done_q;
    assign format_error = format_error_q;

endmodule
